// File: rtl/core_if_pkg.sv
// Shared constants and types for the core_if instruction fetch stage.
package core_if_pkg;

  localparam logic [31:0] CORE_INS_NOP     = 32'h0000_0013;
  localparam logic [31:0] CORE_IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    CORE_IF_ST_FETCH   = 2'b00,
    CORE_IF_ST_WAIT    = 2'b01,
    CORE_IF_ST_DISCARD = 2'b10,
    CORE_IF_ST_STOP    = 2'b11
  } core_if_state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] ins;
  } core_if_entry_t;

  function automatic logic [31:0] core_if_next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/core_if_fifo.sv
// Synchronous prefetch FIFO of {err, pc, ins} entries; clear overrides push and pop.
module core_if_fifo
  import core_if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  core_if_entry_t i_data,
  input  logic           i_pop,
  input  logic           i_clear,
  output core_if_entry_t o_head,
  output logic [CW-1:0]  o_count,
  output logic           o_full,
  output logic           o_empty
);

  core_if_entry_t r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (rst && !i_clear && w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/core_if.sv
// Instruction fetch stage: req/ack bus fetch into a prefetch FIFO feeding decode.
// Optional CORE_IF_ALIGN_CHECK_EN faults misaligned redirect targets instead of aligning them.
module core_if
  import core_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CORE_IF_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INS    = CORE_INS_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_id_halt,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_im_req,
  output logic [31:0] o_im_addr,
  input  logic        i_im_ack,
  input  logic [31:0] i_im_rdata,
  input  logic        i_im_err,
  output logic [31:0] o_if_ins,
  output logic [31:0] o_if_pc,
  output logic        o_if_valid,
  output logic        o_if_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  core_if_state_e r_state;
  logic [31:0]    r_fetch_pc;
  logic [31:0]    r_req_addr;
  logic           r_flt_pend;
  logic [31:0]    r_if_ins;
  logic [31:0]    r_if_pc;
  logic           r_if_valid;
  logic           r_if_err;

  logic           w_outst;
  logic           w_req;
  logic           w_ack;
  logic           w_bus_push;
  logic           w_flt_push;
  logic           w_push;
  logic           w_pop;
  logic           w_misalign;
  logic [31:0]    w_addr;
  logic [31:0]    w_redir_pc;
  core_if_entry_t w_push_data;
  core_if_entry_t w_head;
  logic [CW-1:0]  w_count;
  logic           w_full;
  logic           w_empty;

`ifdef CORE_IF_ALIGN_CHECK_EN
  assign w_redir_pc = i_redirect_pc;
  assign w_misalign = (i_redirect_pc[1:0] != 2'b00);
`else
  assign w_redir_pc = i_redirect_pc & 32'hFFFF_FFFC;
  assign w_misalign = 1'b0;
`endif

  // An in-flight request pins the bus; a new one needs room for its reply
  assign w_outst    = (r_state == CORE_IF_ST_WAIT) || (r_state == CORE_IF_ST_DISCARD);
  assign w_req      = w_outst || ((r_state == CORE_IF_ST_FETCH) && (w_count < CW'(FIFO_DEPTH)));
  assign w_ack      = w_req && i_im_ack;
  assign w_addr     = w_outst ? r_req_addr : r_fetch_pc;
  assign w_bus_push = w_ack && ((r_state == CORE_IF_ST_FETCH) || (r_state == CORE_IF_ST_WAIT));
  assign w_flt_push = (r_state == CORE_IF_ST_STOP) && r_flt_pend;
  assign w_push     = (w_bus_push || w_flt_push) && !w_full;
  assign w_pop      = !i_id_halt && !w_empty;

  assign o_im_req   = rst && w_req;
  assign o_im_addr  = w_addr;
  assign o_if_ins   = r_if_ins;
  assign o_if_pc    = r_if_pc;
  assign o_if_valid = r_if_valid;
  assign o_if_err   = r_if_err;

  // Entry source: bus response or synthesised alignment fault
  always_comb begin
    w_push_data = '{err: i_im_err, pc: w_addr, ins: i_im_rdata};
    if (w_flt_push) begin
      w_push_data = '{err: 1'b1, pc: r_fetch_pc, ins: NOP_INS};
    end else begin
      w_push_data = '{err: i_im_err, pc: w_addr, ins: i_im_rdata};
    end
  end

  core_if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_clear (i_redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Bus FSM and fetch address
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= CORE_IF_ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_flt_pend <= 1'b0;
    end else if (i_redirect) begin
      r_fetch_pc <= w_redir_pc;
      r_flt_pend <= w_misalign;
      if (w_req && !i_im_ack) begin
        r_state    <= CORE_IF_ST_DISCARD;
        r_req_addr <= w_addr;
      end else if (w_misalign) begin
        r_state <= CORE_IF_ST_STOP;
      end else begin
        r_state <= CORE_IF_ST_FETCH;
      end
    end else begin
      case (r_state)
        CORE_IF_ST_FETCH: begin
          if (w_ack) begin
            r_fetch_pc <= core_if_next_pc(r_fetch_pc);
            if (i_im_err) r_state <= CORE_IF_ST_STOP;
          end else if (w_req) begin
            r_state    <= CORE_IF_ST_WAIT;
            r_req_addr <= r_fetch_pc;
          end
        end
        CORE_IF_ST_WAIT: begin
          if (w_ack) begin
            r_fetch_pc <= core_if_next_pc(r_fetch_pc);
            r_state    <= i_im_err ? CORE_IF_ST_STOP : CORE_IF_ST_FETCH;
          end
        end
        CORE_IF_ST_DISCARD: begin
          if (w_ack) r_state <= r_flt_pend ? CORE_IF_ST_STOP : CORE_IF_ST_FETCH;
        end
        CORE_IF_ST_STOP: begin
          if (w_push) r_flt_pend <= 1'b0;
        end
        default: r_state <= CORE_IF_ST_FETCH;
      endcase
    end
  end

  // Decode-facing output register; if_pc keeps its value across bubbles
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_ins   <= NOP_INS;
      r_if_pc    <= 32'h0000_0000;
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
    end else if (i_redirect) begin
      r_if_ins   <= NOP_INS;
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
    end else if (w_pop) begin
      r_if_ins   <= w_head.err ? NOP_INS : w_head.ins;
      r_if_pc    <= w_head.pc;
      r_if_valid <= !w_head.err;
      r_if_err   <= w_head.err;
    end else if (!i_id_halt) begin
      r_if_ins   <= NOP_INS;
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
    end
  end

endmodule
